// File: rtl/digit_scan.sv
// Four-digit multiplexed display scanner with guard time and frame-synchronous double buffering.
// Define DIGIT_SCAN_LZB_EN to enable leading-zero blanking of digits 1..3.
module digit_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  nib,
  output logic [3:0]  dsel,
  output logic        blank_o,
  output logic        tick,
  output logic        frame
);

  localparam int MAXC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {GUARD, SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   shadow, shadow_n;
  logic [15:0]   disp, disp_n;
  logic          pending, pending_n;
  logic          adv, adv_n;
  logic          wrap, wrap_n;
  logic          lzb;
  logic [3:0]    nib_n, dsel_n;
  logic          blank_n, tick_n, frame_n;

`ifdef DIGIT_SCAN_LZB_EN
  always_comb begin
    case (idx)
      2'd1:    lzb = (disp[15:4] == 12'h000);
      2'd2:    lzb = (disp[15:8] == 8'h00);
      2'd3:    lzb = (disp[15:12] == 4'h0);
      default: lzb = 1'b0;
    endcase
  end
`else
  assign lzb = 1'b0;
`endif

  // Outputs are registered from the current-cycle state, so they trail it by one edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    adv_n     = 1'b0;
    wrap_n    = 1'b0;
    case (state)
      GUARD: begin
        if (cnt == CW'(GUARD_CYC - 1)) begin
          state_n = SHOW;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          state_n = GUARD;
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
          adv_n   = 1'b1;
          wrap_n  = (idx == 2'd3);
        end
      end
      default: begin
        state_n = GUARD;
        cnt_n   = '0;
      end
    endcase

    tick_n    = adv;
    frame_n   = adv & wrap;

    // A load on the boundary edge lands in shadow first and is promoted in the same edge.
    shadow_n  = load ? value : shadow;
    pending_n = pending | load;
    disp_n    = disp;
    if (frame_n && pending_n) begin
      disp_n    = shadow_n;
      pending_n = 1'b0;
    end

    nib_n     = nib;
    dsel_n    = 4'b0000;
    blank_n   = 1'b1;
    if (state == SHOW) begin
      dsel_n  = 4'b0001 << idx;
      nib_n   = disp[{idx, 2'b00} +: 4];
      blank_n = blank_mask[idx] | lzb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= GUARD;
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      disp    <= 16'h0000;
      pending <= 1'b0;
      adv     <= 1'b0;
      wrap    <= 1'b0;
      nib     <= 4'h0;
      dsel    <= 4'b0000;
      blank_o <= 1'b1;
      tick    <= 1'b0;
      frame   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shadow  <= shadow_n;
      disp    <= disp_n;
      pending <= pending_n;
      adv     <= adv_n;
      wrap    <= wrap_n;
      nib     <= nib_n;
      dsel    <= dsel_n;
      blank_o <= blank_n;
      tick    <= tick_n;
      frame   <= frame_n;
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// Randomized bench for digit_scan against a cycle-position reference model (SCAN_DIV=4, GUARD_CYC=2).
module tb_digit_scan;

  localparam int SD    = 4;
  localparam int GC    = 2;
  localparam int DIG   = SD + GC;
  localparam int FRAME = 4 * DIG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  nib, dsel;
  logic        blank_o, tick, frame;

  int total = 0;
  int bad = 0;

  // reference model state
  int          c = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_disp = 16'h0000;
  bit          m_pend = 1'b0;
  logic [3:0]  e_nib = 4'h0;

  digit_scan #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_mask(blank_mask),
    .nib(nib), .dsel(dsel), .blank_o(blank_o), .tick(tick), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at c=%0d: got=%h want=%h", tag, c, got, exp);
    end
  endtask

  function automatic bit lzbm(input int k);
`ifdef DIGIT_SCAN_LZB_EN
    if (k == 0) return 1'b0;
    return ((m_disp >> (4 * k)) == 16'h0000);
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_reset();
    c = 0; m_shadow = 16'h0000; m_disp = 16'h0000; m_pend = 1'b0; e_nib = 4'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dsel"},  16'(dsel),    16'h0000);
    chk({tag, "_blank"}, 16'(blank_o), 16'h0001);
    chk({tag, "_nib"},   16'(nib),     16'h0000);
    chk({tag, "_tick"},  16'(tick),    16'h0000);
    chk({tag, "_frame"}, 16'(frame),   16'h0000);
  endtask

  // Called at a negedge: drive inputs, take one edge, predict and check, return at next negedge.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] m);
    int fc, dg, ph;
    logic [3:0] e_dsel;
    logic e_blank, e_tick, e_frame;
    load = ld; value = v; blank_mask = m;
    @(posedge clk);
    fc = c % FRAME; dg = fc / DIG; ph = fc % DIG;
    if (ph < GC) begin
      e_dsel = 4'b0000; e_blank = 1'b1;
    end else begin
      e_dsel  = 4'(1 << dg);
      e_nib   = m_disp[4*dg +: 4];
      e_blank = m[dg] | lzbm(dg);
    end
    e_tick  = (c > 0) && (ph == 0);
    e_frame = (c > 0) && (fc == 0);
    if (ld) begin m_shadow = v; m_pend = 1'b1; end
    if (e_frame && m_pend) begin m_disp = m_shadow; m_pend = 1'b0; end
    #1;
    chk("dsel",  16'(dsel),    16'(e_dsel));
    chk("nib",   16'(nib),     16'(e_nib));
    chk("blank", 16'(blank_o), 16'(e_blank));
    chk("tick",  16'(tick),    16'(e_tick));
    chk("frame", 16'(frame),   16'(e_frame));
    c++;
    @(negedge clk);
  endtask

  task automatic idle_to(input int target, input logic [3:0] m);
    while (c < target) cyc(1'b0, 16'($urandom), m);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    model_reset();

    // plain scan, deferred load, last-load-wins
    idle_to(8, 4'h0);
    cyc(1'b1, 16'h1234, 4'h0);
    idle_to(50, 4'h0);
    cyc(1'b1, 16'hAAAA, 4'h0);
    idle_to(60, 4'h0);
    cyc(1'b1, 16'h5555, 4'h0);
    // blanking with forced mask, then all-zero value
    idle_to(80, 4'h0);
    cyc(1'b1, 16'h0007, 4'b0100);
    idle_to(100, 4'b0100);
    cyc(1'b1, 16'h0000, 4'b0100);
    idle_to(144, 4'b0100);
    // load on the frame-boundary edge
    cyc(1'b1, 16'hBEEF, 4'h0);
    idle_to(170, 4'h0);

    repeat (200) begin
      logic [15:0] rv;
      rv = 16'($urandom) >> $urandom_range(0, 15);
      cyc($urandom_range(0, 7) == 0, rv, 4'($urandom));
    end

    // reset during the digit-2 SHOW with a load pending
    while ((c % FRAME) != 9) cyc(1'b0, 16'($urandom), 4'h0);
    cyc(1'b1, 16'h9ABC, 4'h0);
    while ((c % FRAME) != 17) cyc(1'b0, 16'($urandom), 4'h0);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    repeat (3) @(negedge clk);
    chk_reset("hold");
    rst_n = 1'b1;
    model_reset();
    idle_to(60, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
